// File: rtl/cache_pkg.sv
// Shared geometry, tag entry layout and FSM encoding for the data cache controller.
package cache_pkg;

   localparam int TAG_W    = 55;
   localparam int INDEX_W  = 4;
   localparam int OFFSET_W = 5;
   localparam int LINE_W   = 256;
   localparam int WORD_W   = 64;
   localparam int ENTRY_W  = TAG_W + 2;
   localparam int ADDR_W   = 64;

   localparam int VALID_BIT = 56;
   localparam int DIRTY_BIT = 55;

   // FSM encoding kept as plain constants so older tools reading the state bits still work
   localparam logic [1:0] ST_IDLE      = 2'd0;
   localparam logic [1:0] ST_COMPARE   = 2'd1;
   localparam logic [1:0] ST_WRITEBACK = 2'd2;
   localparam logic [1:0] ST_ALLOCATE  = 2'd3;

   // Packs {valid, dirty, tag} into the layout the tag array stores
   function automatic logic [ENTRY_W-1:0] make_tag_entry(input logic valid,
                                                        input logic dirty,
                                                        input logic [TAG_W-1:0] tag);
      return {valid, dirty, tag};
   endfunction

endpackage

// File: rtl/cache_ctrl_if.sv
// Bundles the CPU request/response, tag/data array and backing-memory signals of the controller.
interface cache_ctrl_if;
   import cache_pkg::*;

   logic                req_valid_i;
   logic                req_ready_o;
   logic                req_we_i;
   logic [ADDR_W-1:0]   req_addr_i;
   logic [WORD_W-1:0]   req_wdata_i;
   logic                resp_valid_o;
   logic [WORD_W-1:0]   resp_rdata_o;

   logic [INDEX_W-1:0]  tag_index_o;
   logic                tag_we_o;
   logic [ENTRY_W-1:0]  tag_write_o;
   logic [ENTRY_W-1:0]  tag_read_i;
   logic [INDEX_W-1:0]  data_index_o;
   logic                data_we_o;
   logic [LINE_W-1:0]   data_write_o;
   logic [LINE_W-1:0]   data_read_i;

   logic                mem_req_o;
   logic                mem_we_o;
   logic [ADDR_W-1:0]   mem_addr_o;
   logic [LINE_W-1:0]   mem_wdata_o;
   logic                mem_ack_i;
   logic [LINE_W-1:0]   mem_rdata_i;

   logic [15:0]         hit_cnt_o;
   logic [15:0]         miss_cnt_o;

   // The controller side
   modport slave (
      input  req_valid_i, req_we_i, req_addr_i, req_wdata_i,
      input  tag_read_i, data_read_i, mem_ack_i, mem_rdata_i,
      output req_ready_o, resp_valid_o, resp_rdata_o,
      output tag_index_o, tag_we_o, tag_write_o,
      output data_index_o, data_we_o, data_write_o,
      output mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o,
      output hit_cnt_o, miss_cnt_o
   );

   // The surrounding pipeline, arrays and memory
   modport master (
      output req_valid_i, req_we_i, req_addr_i, req_wdata_i,
      output tag_read_i, data_read_i, mem_ack_i, mem_rdata_i,
      input  req_ready_o, resp_valid_o, resp_rdata_o,
      input  tag_index_o, tag_we_o, tag_write_o,
      input  data_index_o, data_we_o, data_write_o,
      input  mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o,
      input  hit_cnt_o, miss_cnt_o
   );

endinterface

// File: rtl/cache_line_merge.sv
// Replaces one 64-bit word of a cache line and extracts the same word for loads.
module cache_line_merge
   import cache_pkg::*;
(
   input  logic [LINE_W-1:0] line_in,
   input  logic [WORD_W-1:0] word_in,
   input  logic [1:0]        word_sel,
   output logic [LINE_W-1:0] line_out,
   output logic [WORD_W-1:0] word_out
);

   logic [7:0] bit_base;

   assign bit_base = {word_sel, 6'b0};

   // Overwrite the selected word in a copy of the line; read the original word out
   always_comb begin
      line_out = line_in;
      line_out[bit_base +: WORD_W] = word_in;
      word_out = line_in[bit_base +: WORD_W];
   end

endmodule

// File: rtl/cache_ctrl.sv
// Direct-mapped write-back/write-allocate data cache controller: lookup, writeback, refill.
module cache_ctrl
   import cache_pkg::*;
(
   input  logic         clk_i,
   input  logic         rst_i,
   cache_ctrl_if.slave  bus
);

   logic [1:0]          state_q;
   logic [1:0]          state_d;
   logic                we_q;
   logic [TAG_W-1:0]    tag_q;
   logic [INDEX_W-1:0]  index_q;
   logic [1:0]          word_q;
   logic [WORD_W-1:0]   wdata_q;
   logic                refill_q;
   logic                resp_valid_q;
   logic [WORD_W-1:0]   resp_rdata_q;
   logic [15:0]         hit_cnt_q;
   logic [15:0]         miss_cnt_q;

   logic [TAG_W-1:0]    stored_tag;
   logic                hit;
   logic                victim_dirty;
   logic [LINE_W-1:0]   merged_line;
   logic [WORD_W-1:0]   selected_word;
   logic                unused_addr_bits;

   assign stored_tag       = bus.tag_read_i[TAG_W-1:0];
   assign hit              = bus.tag_read_i[VALID_BIT] && (stored_tag == tag_q);
   assign victim_dirty     = bus.tag_read_i[VALID_BIT] && bus.tag_read_i[DIRTY_BIT];
   assign unused_addr_bits = ^bus.req_addr_i[2:0];

   cache_line_merge u_merge (
      .line_in  (bus.data_read_i),
      .word_in  (wdata_q),
      .word_sel (word_q),
      .line_out (merged_line),
      .word_out (selected_word)
   );

   assign bus.tag_index_o  = index_q;
   assign bus.data_index_o = index_q;
   assign bus.resp_valid_o = resp_valid_q;
   assign bus.resp_rdata_o = resp_rdata_q;
   assign bus.hit_cnt_o    = hit_cnt_q;
   assign bus.miss_cnt_o   = miss_cnt_q;

   // Next-state logic plus the memory and array strobes, all decoded from the current state
   always_comb begin
      state_d          = state_q;
      bus.req_ready_o  = (state_q == ST_IDLE);
      bus.mem_req_o    = 1'b0;
      bus.mem_we_o     = 1'b0;
      bus.mem_addr_o   = '0;
      bus.mem_wdata_o  = '0;
      bus.tag_we_o     = 1'b0;
      bus.tag_write_o  = '0;
      bus.data_we_o    = 1'b0;
      bus.data_write_o = '0;
      case (state_q)
         ST_IDLE: begin
            if (bus.req_valid_i) state_d = ST_COMPARE;
         end
         ST_COMPARE: begin
            if (hit) begin
               if (we_q) begin
                  bus.data_we_o    = !rst_i;
                  bus.data_write_o = merged_line;
                  bus.tag_we_o     = !rst_i;
                  bus.tag_write_o  = make_tag_entry(1'b1, 1'b1, tag_q);
               end
               state_d = ST_IDLE;
            end else if (victim_dirty) begin
               state_d = ST_WRITEBACK;
            end else begin
               state_d = ST_ALLOCATE;
            end
         end
         ST_WRITEBACK: begin
            bus.mem_req_o   = 1'b1;
            bus.mem_we_o    = 1'b1;
            bus.mem_addr_o  = {stored_tag, index_q, {OFFSET_W{1'b0}}};
            bus.mem_wdata_o = bus.data_read_i;
            if (bus.mem_ack_i) state_d = ST_ALLOCATE;
         end
         default: begin
            bus.mem_req_o  = 1'b1;
            bus.mem_addr_o = {tag_q, index_q, {OFFSET_W{1'b0}}};
            if (bus.mem_ack_i) begin
               bus.data_we_o    = !rst_i;
               bus.data_write_o = bus.mem_rdata_i;
               bus.tag_we_o     = !rst_i;
               bus.tag_write_o  = make_tag_entry(1'b1, 1'b0, tag_q);
               state_d          = ST_COMPARE;
            end
         end
      endcase
   end

   // State register, request latch, registered response and the hit/miss statistics
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q      <= ST_IDLE;
         we_q         <= 1'b0;
         tag_q        <= '0;
         index_q      <= '0;
         word_q       <= '0;
         wdata_q      <= '0;
         refill_q     <= 1'b0;
         resp_valid_q <= 1'b0;
         resp_rdata_q <= '0;
         hit_cnt_q    <= '0;
         miss_cnt_q   <= '0;
      end else begin
         state_q      <= state_d;
         resp_valid_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (bus.req_valid_i) begin
                  we_q     <= bus.req_we_i;
                  tag_q    <= bus.req_addr_i[63:9];
                  index_q  <= bus.req_addr_i[8:5];
                  word_q   <= bus.req_addr_i[4:3];
                  wdata_q  <= bus.req_wdata_i;
                  refill_q <= 1'b0;
               end
            end
            ST_COMPARE: begin
               if (hit) begin
                  resp_valid_q <= 1'b1;
                  resp_rdata_q <= we_q ? '0 : selected_word;
                  if (!refill_q) hit_cnt_q <= hit_cnt_q + 16'd1;
               end else if (!refill_q) begin
                  miss_cnt_q <= miss_cnt_q + 16'd1;
               end
            end
            ST_ALLOCATE: begin
               if (bus.mem_ack_i) refill_q <= 1'b1;
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: tb/tb_cache_ctrl.sv
// Directed self-checking bench for cache_ctrl with behavioural tag/data arrays.
module tb_cache_ctrl;
   import cache_pkg::*;

   logic clk;
   logic rst;
   int   tests_run;
   int   tests_failed;

   logic [ENTRY_W-1:0] tag_mem  [16];
   logic [LINE_W-1:0]  data_mem [16];

   localparam logic [LINE_W-1:0] LINE1 = {64'h4444, 64'h3333, 64'h2222, 64'h1111};
   localparam logic [LINE_W-1:0] LINE1_ST = {64'hDEAD, 64'h3333, 64'h2222, 64'h1111};
   localparam logic [LINE_W-1:0] LINE2 = {64'h8888, 64'h7777, 64'h6666, 64'h5555};
   localparam logic [LINE_W-1:0] JUNK  = {4{64'hBADBADBADBADBAD0}};

   cache_ctrl_if bus ();

   cache_ctrl dut (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (bus)
   );

   // Free-running clock, rising edges at 5, 15, 25 ...
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   assign bus.tag_read_i  = tag_mem[bus.tag_index_o];
   assign bus.data_read_i = data_mem[bus.data_index_o];

   // Behavioural tag and data arrays: edge-triggered writes, combinational reads
   always @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 16; i++) begin
            tag_mem[i]  <= '0;
            data_mem[i] <= '0;
         end
      end else begin
         if (bus.tag_we_o)  tag_mem[bus.tag_index_o]   <= bus.tag_write_o;
         if (bus.data_we_o) data_mem[bus.data_index_o] <= bus.data_write_o;
      end
   end

   // Safety net in case something stalls the sequence
   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   // Presents one request for a single cycle; returns at the negedge where COMPARE is active
   task automatic send_req(input logic we, input logic [63:0] addr, input logic [63:0] wdata);
      bus.req_valid_i = 1'b1;
      bus.req_we_i    = we;
      bus.req_addr_i  = addr;
      bus.req_wdata_i = wdata;
      @(negedge clk);
      bus.req_valid_i = 1'b0;
      bus.req_we_i    = 1'b0;
      bus.req_addr_i  = '0;
      bus.req_wdata_i = '0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(negedge clk);
      tests_run++;
      if (bus.mem_req_o !== 1'b0 || bus.resp_valid_o !== 1'b0) begin
         tests_failed++;
         $display("[TB] FAIL reset_outputs: mem_req=%0b resp_valid=%0b, want 0 0", bus.mem_req_o, bus.resp_valid_o);
      end
      tests_run++;
      if (bus.hit_cnt_o !== 16'd0 || bus.miss_cnt_o !== 16'd0) begin
         tests_failed++;
         $display("[TB] FAIL reset_counters: hit=%0d miss=%0d, want 0 0", bus.hit_cnt_o, bus.miss_cnt_o);
      end
      tests_run++;
      if (bus.tag_we_o !== 1'b0 || bus.data_we_o !== 1'b0) begin
         tests_failed++;
         $display("[TB] FAIL reset_we: tag_we=%0b data_we=%0b, want 0 0", bus.tag_we_o, bus.data_we_o);
      end
      rst = 1'b0;
      @(negedge clk);
      tests_run++;
      if (bus.req_ready_o !== 1'b1) begin
         tests_failed++;
         $display("[TB] FAIL reset_ready: got %0b want 1", bus.req_ready_o);
      end
   endtask

   task automatic test_clean_miss();
      send_req(1'b0, 64'h200, 64'h0);
      tests_run++;
      if (bus.req_ready_o !== 1'b0 || bus.mem_req_o !== 1'b0) begin
         tests_failed++;
         $display("[TB] FAIL miss_compare: ready=%0b mem_req=%0b, want 0 0", bus.req_ready_o, bus.mem_req_o);
      end
      @(negedge clk);
      tests_run++;
      if (bus.mem_req_o !== 1'b1 || bus.mem_we_o !== 1'b0 || bus.mem_addr_o !== 64'h200) begin
         tests_failed++;
         $display("[TB] FAIL miss_alloc_req: req=%0b we=%0b addr=%h, want 1 0 200", bus.mem_req_o, bus.mem_we_o, bus.mem_addr_o);
      end
      @(negedge clk);
      tests_run++;
      if (bus.mem_req_o !== 1'b1 || bus.mem_addr_o !== 64'h200 || bus.tag_we_o !== 1'b0) begin
         tests_failed++;
         $display("[TB] FAIL miss_alloc_hold: req=%0b addr=%h tag_we=%0b, want 1 200 0", bus.mem_req_o, bus.mem_addr_o, bus.tag_we_o);
      end
      bus.mem_ack_i   = 1'b1;
      bus.mem_rdata_i = LINE1;
      #1;
      tests_run++;
      if (bus.data_we_o !== 1'b1 || bus.data_write_o !== LINE1) begin
         tests_failed++;
         $display("[TB] FAIL miss_refill_data: we=%0b line=%h, want 1 %h", bus.data_we_o, bus.data_write_o, LINE1);
      end
      tests_run++;
      if (bus.tag_we_o !== 1'b1 || bus.tag_write_o !== {1'b1, 1'b0, 55'h1}) begin
         tests_failed++;
         $display("[TB] FAIL miss_refill_tag: we=%0b entry=%h, want 1 %h", bus.tag_we_o, bus.tag_write_o, {1'b1, 1'b0, 55'h1});
      end
      @(negedge clk);
      bus.mem_ack_i   = 1'b0;
      bus.mem_rdata_i = '0;
      tests_run++;
      if (bus.resp_valid_o !== 1'b0 || bus.req_ready_o !== 1'b0) begin
         tests_failed++;
         $display("[TB] FAIL miss_recompare: resp_valid=%0b ready=%0b, want 0 0", bus.resp_valid_o, bus.req_ready_o);
      end
      @(negedge clk);
      tests_run++;
      if (bus.resp_valid_o !== 1'b1 || bus.resp_rdata_o !== 64'h1111 || bus.req_ready_o !== 1'b1) begin
         tests_failed++;
         $display("[TB] FAIL miss_resp: valid=%0b data=%h ready=%0b, want 1 1111 1", bus.resp_valid_o, bus.resp_rdata_o, bus.req_ready_o);
      end
      tests_run++;
      if (bus.miss_cnt_o !== 16'd1 || bus.hit_cnt_o !== 16'd0) begin
         tests_failed++;
         $display("[TB] FAIL miss_counters: miss=%0d hit=%0d, want 1 0", bus.miss_cnt_o, bus.hit_cnt_o);
      end
      tests_run++;
      if (tag_mem[0] !== {1'b1, 1'b0, 55'h1}) begin
         tests_failed++;
         $display("[TB] FAIL miss_tag_entry: got %h want %h", tag_mem[0], {1'b1, 1'b0, 55'h1});
      end
      @(negedge clk);
      tests_run++;
      if (bus.resp_valid_o !== 1'b0) begin
         tests_failed++;
         $display("[TB] FAIL miss_resp_pulse: got %0b want 0", bus.resp_valid_o);
      end
   endtask

   task automatic test_load_hit();
      send_req(1'b0, 64'h200, 64'h0);
      tests_run++;
      if (bus.data_we_o !== 1'b0 || bus.tag_we_o !== 1'b0 || bus.mem_req_o !== 1'b0) begin
         tests_failed++;
         $display("[TB] FAIL hit_compare: data_we=%0b tag_we=%0b mem_req=%0b, want 0 0 0", bus.data_we_o, bus.tag_we_o, bus.mem_req_o);
      end
      @(negedge clk);
      tests_run++;
      if (bus.resp_valid_o !== 1'b1 || bus.resp_rdata_o !== 64'h1111 || bus.req_ready_o !== 1'b1) begin
         tests_failed++;
         $display("[TB] FAIL hit_resp: valid=%0b data=%h ready=%0b, want 1 1111 1", bus.resp_valid_o, bus.resp_rdata_o, bus.req_ready_o);
      end
      tests_run++;
      if (bus.hit_cnt_o !== 16'd1 || bus.mem_req_o !== 1'b0) begin
         tests_failed++;
         $display("[TB] FAIL hit_count: hit=%0d mem_req=%0b, want 1 0", bus.hit_cnt_o, bus.mem_req_o);
      end
   endtask

   task automatic test_store_hit();
      send_req(1'b1, 64'h218, 64'hDEAD);
      tests_run++;
      if (bus.data_we_o !== 1'b1 || bus.data_write_o !== LINE1_ST) begin
         tests_failed++;
         $display("[TB] FAIL store_data: we=%0b line=%h, want 1 %h", bus.data_we_o, bus.data_write_o, LINE1_ST);
      end
      tests_run++;
      if (bus.tag_we_o !== 1'b1 || bus.tag_write_o !== {1'b1, 1'b1, 55'h1}) begin
         tests_failed++;
         $display("[TB] FAIL store_tag: we=%0b entry=%h, want 1 %h", bus.tag_we_o, bus.tag_write_o, {1'b1, 1'b1, 55'h1});
      end
      @(negedge clk);
      tests_run++;
      if (bus.resp_valid_o !== 1'b1 || bus.resp_rdata_o !== 64'h0 || bus.hit_cnt_o !== 16'd2) begin
         tests_failed++;
         $display("[TB] FAIL store_resp: valid=%0b data=%h hit=%0d, want 1 0 2", bus.resp_valid_o, bus.resp_rdata_o, bus.hit_cnt_o);
      end
   endtask

   task automatic test_dirty_miss();
      send_req(1'b0, 64'h400, 64'h0);
      tests_run++;
      if (bus.mem_req_o !== 1'b0) begin
         tests_failed++;
         $display("[TB] FAIL dirty_compare: mem_req=%0b want 0", bus.mem_req_o);
      end
      @(negedge clk);
      tests_run++;
      if (bus.mem_req_o !== 1'b1 || bus.mem_we_o !== 1'b1 || bus.mem_addr_o !== 64'h200) begin
         tests_failed++;
         $display("[TB] FAIL dirty_wb_req: req=%0b we=%0b addr=%h, want 1 1 200", bus.mem_req_o, bus.mem_we_o, bus.mem_addr_o);
      end
      tests_run++;
      if (bus.mem_wdata_o !== LINE1_ST) begin
         tests_failed++;
         $display("[TB] FAIL dirty_wb_data: got %h want %h", bus.mem_wdata_o, LINE1_ST);
      end
      bus.mem_ack_i   = 1'b1;
      bus.mem_rdata_i = JUNK;
      #1;
      tests_run++;
      if (bus.tag_we_o !== 1'b0 || bus.data_we_o !== 1'b0) begin
         tests_failed++;
         $display("[TB] FAIL dirty_wb_ack_we: tag_we=%0b data_we=%0b, want 0 0", bus.tag_we_o, bus.data_we_o);
      end
      @(negedge clk);
      bus.mem_ack_i   = 1'b0;
      bus.mem_rdata_i = '0;
      tests_run++;
      if (bus.mem_req_o !== 1'b1 || bus.mem_we_o !== 1'b0 || bus.mem_addr_o !== 64'h400) begin
         tests_failed++;
         $display("[TB] FAIL dirty_alloc_req: req=%0b we=%0b addr=%h, want 1 0 400", bus.mem_req_o, bus.mem_we_o, bus.mem_addr_o);
      end
      bus.mem_ack_i   = 1'b1;
      bus.mem_rdata_i = LINE2;
      #1;
      tests_run++;
      if (bus.tag_write_o !== {1'b1, 1'b0, 55'h2} || bus.data_write_o !== LINE2) begin
         tests_failed++;
         $display("[TB] FAIL dirty_refill: entry=%h line=%h, want %h %h", bus.tag_write_o, bus.data_write_o, {1'b1, 1'b0, 55'h2}, LINE2);
      end
      @(negedge clk);
      bus.mem_ack_i   = 1'b0;
      bus.mem_rdata_i = '0;
      @(negedge clk);
      tests_run++;
      if (bus.resp_valid_o !== 1'b1 || bus.resp_rdata_o !== 64'h5555) begin
         tests_failed++;
         $display("[TB] FAIL dirty_resp: valid=%0b data=%h, want 1 5555", bus.resp_valid_o, bus.resp_rdata_o);
      end
      tests_run++;
      if (bus.miss_cnt_o !== 16'd2 || bus.hit_cnt_o !== 16'd2) begin
         tests_failed++;
         $display("[TB] FAIL dirty_counters: miss=%0d hit=%0d, want 2 2", bus.miss_cnt_o, bus.hit_cnt_o);
      end
   endtask

   task automatic test_reset_mid();
      send_req(1'b0, 64'h600, 64'h0);
      @(negedge clk);
      tests_run++;
      if (bus.mem_req_o !== 1'b1 || bus.mem_addr_o !== 64'h600) begin
         tests_failed++;
         $display("[TB] FAIL rstmid_alloc: req=%0b addr=%h, want 1 600", bus.mem_req_o, bus.mem_addr_o);
      end
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      tests_run++;
      if (bus.mem_req_o !== 1'b0 || bus.req_ready_o !== 1'b1 || bus.miss_cnt_o !== 16'd0) begin
         tests_failed++;
         $display("[TB] FAIL rstmid_abandon: mem_req=%0b ready=%0b miss=%0d, want 0 1 0", bus.mem_req_o, bus.req_ready_o, bus.miss_cnt_o);
      end
      bus.mem_ack_i   = 1'b1;
      bus.mem_rdata_i = JUNK;
      #1;
      tests_run++;
      if (bus.tag_we_o !== 1'b0 || bus.data_we_o !== 1'b0 || bus.mem_req_o !== 1'b0) begin
         tests_failed++;
         $display("[TB] FAIL rstmid_late_ack: tag_we=%0b data_we=%0b mem_req=%0b, want 0 0 0", bus.tag_we_o, bus.data_we_o, bus.mem_req_o);
      end
      @(negedge clk);
      bus.mem_ack_i   = 1'b0;
      bus.mem_rdata_i = '0;
      tests_run++;
      if (bus.resp_valid_o !== 1'b0 || tag_mem[0] !== '0) begin
         tests_failed++;
         $display("[TB] FAIL rstmid_no_write: resp_valid=%0b tag0=%h, want 0 0", bus.resp_valid_o, tag_mem[0]);
      end
   endtask

   task automatic test_hit_wrap();
      send_req(1'b0, 64'h200, 64'h0);
      @(negedge clk);
      bus.mem_ack_i   = 1'b1;
      bus.mem_rdata_i = LINE1;
      @(negedge clk);
      bus.mem_ack_i   = 1'b0;
      bus.mem_rdata_i = '0;
      @(negedge clk);
      force dut.hit_cnt_q = 16'hFFFE;
      @(negedge clk);
      release dut.hit_cnt_q;
      send_req(1'b0, 64'h200, 64'h0);
      @(negedge clk);
      tests_run++;
      if (bus.hit_cnt_o !== 16'hFFFF) begin
         tests_failed++;
         $display("[TB] FAIL wrap_ffff: got %h want ffff", bus.hit_cnt_o);
      end
      send_req(1'b0, 64'h200, 64'h0);
      @(negedge clk);
      tests_run++;
      if (bus.hit_cnt_o !== 16'h0000 || bus.resp_rdata_o !== 64'h1111) begin
         tests_failed++;
         $display("[TB] FAIL wrap_zero: hit=%h data=%h, want 0000 1111", bus.hit_cnt_o, bus.resp_rdata_o);
      end
      tests_run++;
      if (bus.miss_cnt_o !== 16'd1) begin
         tests_failed++;
         $display("[TB] FAIL wrap_miss_cnt: got %0d want 1", bus.miss_cnt_o);
      end
   endtask

   // Runs every scenario in order and reports the totals
   initial begin
      tests_run       = 0;
      tests_failed    = 0;
      rst             = 1'b1;
      bus.req_valid_i = 1'b0;
      bus.req_we_i    = 1'b0;
      bus.req_addr_i  = '0;
      bus.req_wdata_i = '0;
      bus.mem_ack_i   = 1'b0;
      bus.mem_rdata_i = '0;
      @(negedge clk);
      test_reset();
      test_clean_miss();
      test_load_hit();
      test_store_hit();
      test_dirty_miss();
      test_reset_mid();
      test_hit_wrap();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
